// File: rtl/ep0_control_sequencer_pkg.sv
// Shared types for the EP0 control-transfer sequencer: token/handshake PIDs,
// control states, setup-packet enums and a saturating byte-count helper.
package ep0_control_sequencer_pkg;

   typedef enum logic [1:0] {
      TOK_SETUP = 2'd0,
      TOK_IN    = 2'd1,
      TOK_OUT   = 2'd2
   } TokenPid;

   typedef enum logic [1:0] {
      HS_ACK   = 2'd0,
      HS_NAK   = 2'd1,
      HS_STALL = 2'd2
   } HsPid;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      SETUP_RX   = 3'd1,
      SETUP_CHK  = 3'd2,
      DATA_IN    = 3'd3,
      DATA_OUT   = 3'd4,
      STATUS_IN  = 3'd5,
      STATUS_OUT = 3'd6,
      STALLED    = 3'd7
   } Ep0State;

   typedef enum logic {
      DIR_OUT = 1'b0,
      DIR_IN  = 1'b1
   } SetupDir;

   typedef enum logic {
      DATA0 = 1'b0,
      DATA1 = 1'b1
   } DataPid;

   localparam logic [6:0] SETUP_PKT_LEN = 7'd8;
   localparam logic [6:0] BYTE_CNT_MAX  = 7'd127;

   function automatic logic [15:0] satSub16(input logic [15:0] a, input logic [6:0] b);
      return (a > {9'd0, b}) ? (a - {9'd0, b}) : 16'd0;
   endfunction

endpackage

// File: rtl/ep0_len_calc.sv
// Next IN packet length for EP0: min(bytesLeft, MAX_PKT), plus a flag telling
// whether that packet is short (and therefore ends the data stage).
module ep0_len_calc #(
   parameter int MAX_PKT = 8
) (
   input  logic [15:0] bytesLeft,
   output logic [6:0]  pktLen,
   output logic        isShort
);

   localparam logic [15:0] MaxPkt16 = 16'(MAX_PKT);

   always_comb begin
      isShort = (bytesLeft < MaxPkt16);
      pktLen  = isShort ? bytesLeft[6:0] : MaxPkt16[6:0];
   end

endmodule

// File: rtl/ep0_control_sequencer.sv
// EP0 control-transfer sequencer: SETUP capture, data stage with toggle and
// remaining-length tracking, status stage and protocol STALL.
//
// state      | meaning
// IDLE       | no transfer; IN/OUT tokens get STALL
// SETUP_RX   | receiving the 8-byte SETUP data packet
// SETUP_CHK  | SETUP accepted: ACK now, req_valid next cycle
// DATA_IN    | device-to-host data stage
// DATA_OUT   | host-to-device data stage
// STATUS_IN  | waiting to send the DATA1 zero-length status packet
// STATUS_OUT | waiting for the host's DATA1 zero-length status packet
// STALLED    | request refused; IN/OUT answered with STALL until next SETUP
module ep0_control_sequencer
   import ep0_control_sequencer_pkg::*;
#(
   parameter int MAX_PKT = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        token_valid,
   input  logic [1:0]  token_pid,
   input  logic        rx_byte_valid,
   input  logic        rx_done,
   input  logic        rx_crc_ok,
   input  logic        rx_data_pid,
   input  logic        dir_in,
   input  logic [15:0] wLength,
   input  logic        app_ready,
   input  logic        app_stall,
   input  logic        tx_done,
   output logic        setup_en,
   output logic        setup_clear,
   output logic        req_valid,
   output logic        hs_send,
   output logic [1:0]  hs_pid,
   output logic        tx_start,
   output logic        tx_data_pid,
   output logic [6:0]  tx_len,
   output logic [2:0]  ctrl_state
);

   localparam logic [6:0] MaxPkt7 = 7'(MAX_PKT);

   Ep0State     state, stateNxt;
   HsPid        hsPid, hsPidNxt;
   logic        toggle, toggleNxt;
   logic [15:0] bytesLeft, bytesLeftNxt;
   logic [6:0]  byteCnt, byteCntNxt;
   logic [6:0]  txLen, txLenNxt;
   logic        txShort, txShortNxt;
   logic        txDataPid, txDataPidNxt;
   logic        hsSend, hsSendNxt;
   logic        setupClear, setupClearNxt;
   logic        reqValid, reqValidNxt;
   logic        txStart, txStartNxt;
   logic        statusInTok;

   logic        tokSetup, tokIn, tokOut, inXfer;
   logic [7:0]  rxSum;
   logic [6:0]  rxLen;
   logic [6:0]  inPktLen;
   logic        inShort;
   logic [15:0] leftAfterTx, leftAfterRx;

   ep0_len_calc #(.MAX_PKT(MAX_PKT)) lenCalc (
      .bytesLeft (bytesLeft),
      .pktLen    (inPktLen),
      .isShort   (inShort)
   );

   assign tokSetup = token_valid && (token_pid == TOK_SETUP);
   assign tokIn    = token_valid && (token_pid == TOK_IN);
   assign tokOut   = token_valid && (token_pid == TOK_OUT);
   assign inXfer   = (state == DATA_IN) || (state == DATA_OUT) ||
                     (state == STATUS_IN) || (state == STATUS_OUT);

   // Packet length includes a byte strobed in the same cycle as rx_done.
   assign rxSum       = {1'b0, byteCnt} + {7'd0, rx_byte_valid};
   assign rxLen       = rxSum[7] ? BYTE_CNT_MAX : rxSum[6:0];
   assign leftAfterTx = satSub16(bytesLeft, txLen);
   assign leftAfterRx = satSub16(bytesLeft, rxLen);

   always_comb begin
      stateNxt      = state;
      hsPidNxt      = hsPid;
      toggleNxt     = toggle;
      bytesLeftNxt  = bytesLeft;
      byteCntNxt    = (token_valid || rx_done) ? 7'd0 : rxLen;
      txLenNxt      = txLen;
      txShortNxt    = txShort;
      txDataPidNxt  = txDataPid;
      hsSendNxt     = 1'b0;
      setupClearNxt = 1'b0;
      reqValidNxt   = 1'b0;
      txStartNxt    = 1'b0;
      statusInTok   = 1'b0;

      if (tokSetup) begin
         setupClearNxt = 1'b1;
         stateNxt      = SETUP_RX;
         toggleNxt     = 1'b0;
         bytesLeftNxt  = 16'd0;
      end else if (inXfer && app_stall) begin
         stateNxt = STALLED;
         if (tokIn || tokOut) begin
            hsSendNxt = 1'b1;
            hsPidNxt  = HS_STALL;
         end
      end else begin
         case (state)
            IDLE, STALLED: begin
               if (tokIn || tokOut) begin
                  hsSendNxt = 1'b1;
                  hsPidNxt  = HS_STALL;
               end
            end
            SETUP_RX: begin
               if (rx_done) begin
                  if (rx_crc_ok && (rx_data_pid == DATA0) && (rxLen == SETUP_PKT_LEN)) begin
                     stateNxt  = SETUP_CHK;
                     hsSendNxt = 1'b1;
                     hsPidNxt  = HS_ACK;
                  end else begin
                     stateNxt = IDLE;
                  end
               end
            end
            SETUP_CHK: begin
               reqValidNxt  = 1'b1;
               toggleNxt    = 1'b1;
               bytesLeftNxt = wLength;
               if (wLength == 16'd0) begin
                  stateNxt = STATUS_IN;
               end else if (dir_in == DIR_IN) begin
                  stateNxt = DATA_IN;
               end else begin
                  stateNxt = DATA_OUT;
               end
            end
            DATA_IN: begin
               if (tokIn) begin
                  if (app_ready) begin
                     txStartNxt   = 1'b1;
                     txLenNxt     = inPktLen;
                     txShortNxt   = inShort;
                     txDataPidNxt = toggle;
                  end else begin
                     hsSendNxt = 1'b1;
                     hsPidNxt  = HS_NAK;
                  end
               end else if (tokOut) begin
                  stateNxt = STATUS_OUT;
               end else if (tx_done) begin
                  toggleNxt    = ~toggle;
                  bytesLeftNxt = leftAfterTx;
                  if ((leftAfterTx == 16'd0) || txShort) begin
                     stateNxt = STATUS_OUT;
                  end
               end
            end
            DATA_OUT: begin
               if (tokIn) begin
                  stateNxt    = STATUS_IN;
                  statusInTok = 1'b1;
               end else if (rx_done && rx_crc_ok) begin
                  hsSendNxt = 1'b1;
                  hsPidNxt  = HS_ACK;
                  // A PID mismatch is a retransmission: ACK it but count nothing.
                  if (rx_data_pid == toggle) begin
                     toggleNxt    = ~toggle;
                     bytesLeftNxt = leftAfterRx;
                     if ((leftAfterRx == 16'd0) || (rxLen < MaxPkt7)) begin
                        stateNxt = STATUS_IN;
                     end
                  end
               end
            end
            STATUS_IN: begin
               if (tokIn) begin
                  statusInTok = 1'b1;
               end else if (tx_done) begin
                  stateNxt = IDLE;
               end
            end
            STATUS_OUT: begin
               if (rx_done && rx_crc_ok && (rx_data_pid == DATA1) && (rxLen == 7'd0)) begin
                  hsSendNxt = 1'b1;
                  hsPidNxt  = HS_ACK;
                  stateNxt  = IDLE;
               end
            end
            default: stateNxt = IDLE;
         endcase

         if (statusInTok) begin
            if (app_ready) begin
               txStartNxt   = 1'b1;
               txLenNxt     = 7'd0;
               txShortNxt   = 1'b1;
               txDataPidNxt = DATA1;
            end else begin
               hsSendNxt = 1'b1;
               hsPidNxt  = HS_NAK;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         hsPid      <= HS_ACK;
         toggle     <= 1'b0;
         bytesLeft  <= 16'd0;
         byteCnt    <= 7'd0;
         txLen      <= 7'd0;
         txShort    <= 1'b0;
         txDataPid  <= 1'b0;
         hsSend     <= 1'b0;
         setupClear <= 1'b0;
         reqValid   <= 1'b0;
         txStart    <= 1'b0;
      end else begin
         state      <= stateNxt;
         hsPid      <= hsPidNxt;
         toggle     <= toggleNxt;
         bytesLeft  <= bytesLeftNxt;
         byteCnt    <= byteCntNxt;
         txLen      <= txLenNxt;
         txShort    <= txShortNxt;
         txDataPid  <= txDataPidNxt;
         hsSend     <= hsSendNxt;
         setupClear <= setupClearNxt;
         reqValid   <= reqValidNxt;
         txStart    <= txStartNxt;
      end
   end

   assign setup_en    = (state == SETUP_RX);
   assign setup_clear = setupClear;
   assign req_valid   = reqValid;
   assign hs_send     = hsSend;
   assign hs_pid      = hsPid;
   assign tx_start    = txStart;
   assign tx_data_pid = txDataPid;
   assign tx_len      = txLen;
   assign ctrl_state  = state;

endmodule

// File: doc/ep0_control_sequencer.md
EP0_CONTROL_SEQUENCER -- requirements
Module: ep0_control_sequencer

Interface
REQ-001 SHALL have parameter MAX_PKT, default 8, EP0 max packet size in bytes (8/16/32/64).
REQ-002 SHALL have ports: clk in 1, clock; reset in 1, synchronous, active-high.
REQ-003 SHALL have token_valid in 1, one-cycle pulse for a decoded token addressed to this device, endpoint 0.
REQ-004 SHALL have token_pid in 2 (TokenPid: SETUP/IN/OUT), sampled with token_valid.
REQ-005 SHALL have rx_byte_valid in 1, rx_done in 1 (end-of-packet pulse), rx_crc_ok in 1 (valid with rx_done) and rx_data_pid in 1 (0=DATA0, 1=DATA1, valid with rx_done).
REQ-006 SHALL have dir_in in 1 (bmRequestTypeDPTD, 1=device-to-host) and wLength in 16, both from the setup buffer.
REQ-007 SHALL have app_ready in 1 (data/status may proceed) and app_stall in 1 (request unsupported).
REQ-008 SHALL have tx_done in 1, a pulse when a transmitted data packet finishes.
REQ-009 SHALL have outputs setup_en 1, setup_clear 1, req_valid 1, hs_send 1, hs_pid 2 (HsPid: ACK/NAK/STALL), tx_start 1, tx_data_pid 1, tx_len 7, and ctrl_state 3.

Function
REQ-010 SHALL use states IDLE, SETUP_RX, SETUP_CHK, DATA_IN, DATA_OUT, STATUS_IN, STATUS_OUT, STALLED, encoded on ctrl_state as 0..7.
REQ-011 SETUP token in any state SHALL pulse setup_clear for 1 cycle, enter SETUP_RX and abort any transfer in progress; SETUP has priority over every other event in the same cycle.
REQ-012 In SETUP_RX, setup_en SHALL be 1 and is 0 in all other states.
REQ-013 rx_done in SETUP_RX SHALL move to SETUP_CHK if rx_crc_ok=1, rx_data_pid=0 and exactly 8 bytes were counted; otherwise it returns to IDLE with no handshake.
REQ-014 SETUP_CHK SHALL pulse hs_send with ACK (hs_pid valid the same cycle), pulse req_valid one cycle later, and reset the data toggle to 1 and bytes_left to wLength.
REQ-015 After SETUP_CHK: wLength=0 goes to STATUS_IN; dir_in=1 goes to DATA_IN; otherwise to DATA_OUT.
REQ-016 In DATA_IN, an IN token SHALL pulse tx_start with tx_len=min(bytes_left, MAX_PKT) and tx_data_pid=toggle if app_ready=1; otherwise it sends NAK.
REQ-017 tx_done SHALL flip toggle and subtract tx_len from bytes_left; transfer ends when bytes_left reaches 0 or tx_len<MAX_PKT, then goes to STATUS_OUT.
REQ-018 A zero-length packet SHALL be sent when bytes_left=0 at an IN token in DATA_IN.
REQ-019 In DATA_OUT, a good OUT packet whose rx_data_pid equals toggle SHALL be ACKed, flip toggle and reduce bytes_left (saturating at 0); a mismatched PID SHALL be ACKed without changing state or counters; a CRC error SHALL get no handshake.
REQ-020 DATA_OUT SHALL go to STATUS_IN when bytes_left=0 or the packet is shorter than MAX_PKT.
REQ-021 An IN token in DATA_OUT SHALL also end the data stage early and be handled as STATUS_IN.
REQ-022 In STATUS_IN, an IN token SHALL send a DATA1 zero-length packet if app_ready=1, else NAK; tx_done SHALL return to IDLE.
REQ-023 In STATUS_OUT, a good zero-length DATA1 OUT packet SHALL be ACKed and return to IDLE; an OUT token in DATA_IN SHALL enter STATUS_OUT directly (early status).
REQ-024 app_stall=1 in any state after SETUP_CHK SHALL enter STALLED, where every IN/OUT token is answered with STALL until the next SETUP.
REQ-025 Tokens in IDLE other than SETUP SHALL be answered with STALL.
REQ-026 The byte counter SHALL be 7 bits and saturate at 127; bytes_left SHALL be 16 bits.
REQ-027 tx_len SHALL be registered and stable from tx_start until tx_done.

Reset
REQ-028 Reset SHALL force IDLE, toggle=0, bytes_left=0, byte count 0, and all pulse outputs 0; tx_len, hs_pid and tx_data_pid SHALL be 0.
REQ-029 Reset mid-transfer SHALL take effect on the next clk edge with no handshake emitted.

Structure
REQ-030 TokenPid, HsPid and the Ep0State enumeration SHALL live in the shared types package alongside the setup enums.
REQ-031 A sub-module ep0_len_calc SHALL compute min(bytes_left, MAX_PKT) and the short-packet flag.

Verification
REQ-032 GET_DESCRIPTOR, wLength=18, MAX_PKT=8: tx_len 8/8/2 with PIDs DATA1/DATA0/DATA1, then OUT ZLP ACK, then IDLE.
REQ-033 SET_ADDRESS (wLength=0): SETUP, ACK, req_valid; IN sends DATA1 ZLP; tx_done returns to IDLE.
REQ-034 OUT data wLength=10: DATA1 8B ACK, repeated DATA1 ACKed with bytes_left still 2, DATA0 2B goes to STATUS_IN.
REQ-035 SETUP with a CRC error: no ACK, no req_valid, state IDLE.
REQ-036 app_stall after SETUP: the next IN and OUT tokens get STALL, and a new SETUP recovers.
REQ-037 SETUP arriving mid DATA_IN: setup_clear pulses, state goes to SETUP_RX, and toggle is restarted.
